counter_sweep_ctrl: RTL

Sequencer for the 4-bit up/down counter (count_to, load_en, count_inc, count_dec, flag_count_max, flag_count_min). It accepts a sweep command over a start/ack handshake, loads the limit, and drives increment/decrement phases with a dwell at the top. It repeats for a programmed number of loops, then reports done. It sits between the register/control layer and one counter instance, and is the only driver of that counter's control inputs.

---
 rtl/counter_sweep_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/counter_sweep_ctrl.sv
//==============================================================================
// Module   : counter_sweep_ctrl
// Purpose  : Sequencer for one up/down counter. It accepts a sweep command
//            over a start/ack handshake, loads the limit, and drives the
//            increment and decrement phases with a dwell at the top. It
//            repeats for the programmed number of loops, then pulses done.
//            A watchdog aborts a stuck UP/DOWN phase and raises error.
// Ports    : clk            - system clock, rising edge
//            reset_n        - synchronous active-low reset
//            start          - command valid, sampled only in IDLE
//            start_ack      - one-cycle pulse when a command is accepted
//            cmd_limit      - count limit, latched into count_to
//            cmd_updown     - 1: up then down per loop, 0: up only
//            cmd_loops      - number of sweeps (0 treated as 1)
//            flag_count_max - counter has reached count_to
//            flag_count_min - counter is at 0
//            abort          - (CNT_SWEEP_ABORT_EN only) terminate command
//            count_to       - registered limit to the counter
//            load_en        - counter load strobe (count restarts at 0)
//            count_inc      - counter increment enable
//            count_dec      - counter decrement enable
//            busy           - high in every state except IDLE
//            done           - one-cycle pulse at the end of a command
//            error          - set on timeout, held until next accepted start
// Options  : define CNT_SWEEP_ABORT_EN to add the abort input.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module counter_sweep_ctrl #(
    parameter int WIDTH   = 4,
    parameter int DWELL   = 2,
    parameter int TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    output logic             start_ack,
    input  logic [WIDTH-1:0] cmd_limit,
    input  logic             cmd_updown,
    input  logic [2:0]       cmd_loops,
    input  logic             flag_count_max,
    input  logic             flag_count_min,
`ifdef CNT_SWEEP_ABORT_EN
    input  logic             abort,
`endif
    output logic [WIDTH-1:0] count_to,
    output logic             load_en,
    output logic             count_inc,
    output logic             count_dec,
    output logic             busy,
    output logic             done,
    output logic             error
);

    // One timer serves both the dwell and the UP/DOWN watchdog, so it must
    // be wide enough for whichever of the two limits is larger.
    localparam int c_TMAX = (TIMEOUT > DWELL) ? TIMEOUT : DWELL;
    localparam int c_TW   = $clog2(c_TMAX + 1);

    localparam logic [c_TW-1:0] c_TO_LAST    = c_TW'(TIMEOUT - 1);
    localparam logic [c_TW-1:0] c_DWELL_LAST = c_TW'(DWELL - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_UP    = 3'd2,
        S_DWELL = 3'd3,
        S_DOWN  = 3'd4,
        S_LOOP  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [c_TW-1:0]  r_timer;
    logic [2:0]       r_loops_left;
    logic             r_updown;
    logic [WIDTH-1:0] r_count_to;
    logic             r_start_ack;
    logic             r_error;
    logic             w_accept;
    logic             w_timeout;

    assign w_accept = (r_state == S_IDLE) && start;

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_UP;
            end
            S_UP: begin
                // The flag is checked before the watchdog so that a flag
                // arriving on the last allowed cycle still completes normally.
                if (flag_count_max) begin
                    w_state_nxt = S_DWELL;
                end else if (r_timer == c_TO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DWELL: begin
                if (r_timer == c_DWELL_LAST) begin
                    w_state_nxt = r_updown ? S_DOWN : S_LOOP;
                end
            end
            S_DOWN: begin
                if (flag_count_min) begin
                    w_state_nxt = S_LOOP;
                end else if (r_timer == c_TO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_LOOP: begin
                // Up/down sweeps leave the counter at 0 and can go straight
                // back up; up-only sweeps need a reload to restart from 0.
                if (r_loops_left != 3'd1) begin
                    w_state_nxt = r_updown ? S_UP : S_LOAD;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

`ifdef CNT_SWEEP_ABORT_EN
        // Abort overrides flags and the watchdog. DONE is excluded so that
        // an abort held high cannot produce a second done pulse.
        if (abort && (r_state != S_IDLE) && (r_state != S_DONE)) begin
            w_timeout   = 1'b0;
            w_state_nxt = S_DONE;
        end
`endif
    end

    //--------------------------------------------------------------------------
    // State and datapath registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_loops_left <= '0;
            r_updown     <= 1'b0;
            r_count_to   <= '0;
            r_start_ack  <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_start_ack <= w_accept;

            // Timer restarts on every state change and only runs in the
            // states that are time-limited.
            if (w_state_nxt != r_state) begin
                r_timer <= '0;
            end else if ((r_state == S_UP) || (r_state == S_DOWN) ||
                         (r_state == S_DWELL)) begin
                r_timer <= r_timer + 1'b1;
            end

            if (w_accept) begin
                r_count_to   <= cmd_limit;
                r_updown     <= cmd_updown;
                r_loops_left <= (cmd_loops == 3'd0) ? 3'd1 : cmd_loops;
            end else if (r_state == S_LOOP) begin
                r_loops_left <= r_loops_left - 1'b1;
            end

            if (w_accept) begin
                r_error <= 1'b0;
            end else if (w_timeout) begin
                r_error <= 1'b1;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Outputs: either registers or pure decodes of the state register
    //--------------------------------------------------------------------------
    assign count_to  = r_count_to;
    assign start_ack = r_start_ack;
    assign error     = r_error;
    assign load_en   = (r_state == S_LOAD);
    assign count_inc = (r_state == S_UP);
    assign count_dec = (r_state == S_DOWN);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);

endmodule

`default_nettype wire
